// File: rtl/draw_bird_phys_if.sv
// VGA raster position bundle: the pixel counters from the timing generator
// that drive the draw path and the frame tick.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;

  modport master (output hcount, vcount);
  modport slave  (input  hcount, vcount);
  modport in     (input  hcount, vcount);
endinterface

// File: rtl/draw_bird_phys.sv
// Flappy-bird physics (one update per frame tick) and bird sprite draw.
// Latency: rgb/valid 1 cycle after vin; no backpressure, vin is consumed every cycle.
module draw_bird_phys #(
  parameter int          BIRD_X      = 400,
  parameter int          BIRD_W      = 40,
  parameter int          BIRD_H      = 50,
  parameter int          Y_START     = 300,
  parameter int          SCREEN_H    = 600,
  parameter int          GRAVITY     = 1,
  parameter int          JUMP_V      = 8,
  parameter int          VMAX        = 12,
  parameter logic [11:0] COLOR       = 12'h0F0,
  parameter logic [11:0] FLAP_COLOR  = 12'hFF0,
  parameter int          FLAP_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_rst,
  input  logic        mouse_left,
  vga_if.in           vin,
  output logic [11:0] rgb,
  output logic        valid,
  output logic        collision
);

  localparam int FW = (FLAP_FRAMES < 1) ? 1 : $clog2(FLAP_FRAMES + 1);

  localparam logic signed [11:0] Y_START_S = 12'(Y_START);
  localparam logic signed [11:0] FLOOR_S   = 12'(SCREEN_H - BIRD_H);
  localparam logic signed [11:0] GRAV_S    = 12'(GRAVITY);
  localparam logic signed [11:0] JUMP_S    = 12'(JUMP_V);
  localparam logic signed [11:0] VMAX_S    = 12'(VMAX);
  localparam logic [FW-1:0]      FLAP_LOAD = FW'(FLAP_FRAMES);
  localparam logic [10:0]        TICK_V    = 11'(SCREEN_H);
  localparam logic [11:0]        X_LO      = 12'(BIRD_X);
  localparam logic [11:0]        X_HI      = 12'(BIRD_X + BIRD_W);
  localparam logic [11:0]        H_U       = 12'(BIRD_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic signed [11:0] y, y_nxt;
  logic signed [11:0] vel, vel_nxt;
  logic signed [11:0] vel_inc, vel_calc, y_calc;
  logic              jump_pend, jump_pend_nxt;
  logic              mouse_q;
  logic [FW-1:0]     flap_cnt, flap_nxt;
  logic              collision_nxt;
  logic              tick, rise, apply;
  logic              hit;
  logic [11:0]       hc, vc, yu;

  // Tick sits just past the last visible line, so y never changes mid-frame.
  assign tick    = (vin.hcount == 11'd0) && (vin.vcount == TICK_V);
  assign rise    = mouse_left && !mouse_q;
  assign vel_inc = vel + GRAV_S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      y         <= Y_START_S;
      vel       <= '0;
      jump_pend <= 1'b0;
      mouse_q   <= 1'b0;
      flap_cnt  <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_nxt;
      y         <= y_nxt;
      vel       <= vel_nxt;
      jump_pend <= jump_pend_nxt;
      mouse_q   <= mouse_left;
      flap_cnt  <= flap_nxt;
      collision <= collision_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    y_nxt         = y;
    vel_nxt       = vel;
    jump_pend_nxt = jump_pend;
    flap_nxt      = flap_cnt;
    collision_nxt = collision;
    vel_calc      = '0;
    y_calc        = '0;
    apply         = 1'b0;

    if (rise && (state != DEAD)) begin
      jump_pend_nxt = 1'b1;
    end

    if (game_rst) begin
      state_nxt     = IDLE;
      y_nxt         = Y_START_S;
      vel_nxt       = '0;
      jump_pend_nxt = 1'b0;
      flap_nxt      = '0;
      collision_nxt = 1'b0;
    end else if (tick) begin
      // A press landing exactly on the tick cycle counts toward the next frame.
      jump_pend_nxt = rise && (state != DEAD);
      if (flap_cnt != '0) begin
        flap_nxt = flap_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          if (jump_pend) begin
            apply     = 1'b1;
            state_nxt = FLY;
          end
        end
        FLY:     apply = 1'b1;
        default: apply = 1'b0;
      endcase

      if (apply) begin
        if (jump_pend) begin
          vel_calc = -JUMP_S;
          flap_nxt = FLAP_LOAD;
        end else if (vel_inc > VMAX_S) begin
          vel_calc = VMAX_S;
        end else begin
          vel_calc = vel_inc;
        end
        y_calc = y + vel_calc;

        if (y_calc[11]) begin
          y_nxt   = '0;
          vel_nxt = '0;
        end else if (y_calc >= FLOOR_S) begin
          y_nxt         = FLOOR_S;
          vel_nxt       = '0;
          state_nxt     = DEAD;
          collision_nxt = 1'b1;
        end else begin
          y_nxt   = y_calc;
          vel_nxt = vel_calc;
        end
      end
    end
  end

  // y is clamped to [0, floor], so the unsigned view is exact.
  always_comb begin
    hc  = {1'b0, vin.hcount};
    vc  = {1'b0, vin.vcount};
    yu  = $unsigned(y);
    hit = (hc >= X_LO) && (hc < X_HI) && (vc >= yu) && (vc < yu + H_U);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb   <= 12'h000;
      valid <= 1'b0;
    end else begin
      valid <= hit;
      if (!hit) begin
        rgb <= 12'h000;
      end else if (flap_cnt != '0) begin
        rgb <= FLAP_COLOR;
      end else begin
        rgb <= COLOR;
      end
    end
  end

endmodule

// File: doc/draw_bird_phys.md
DRAW_BIRD_PHYS -- requirements
Module: draw_bird_phys

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose parameter BIRD_X, 400: left edge of the bird, in pixels.
REQ-002 The block SHALL expose parameter BIRD_W, 40: bird width, in pixels.
REQ-003 The block SHALL expose parameter BIRD_H, 50: bird height, in pixels.
REQ-004 The block SHALL expose parameter Y_START, 300: bird top row after reset or game_rst.
REQ-005 The block SHALL expose parameter SCREEN_H, 600: visible line count; the floor is at y = SCREEN_H - BIRD_H.
REQ-006 The block SHALL expose parameter GRAVITY, 1: velocity increment per frame.
REQ-007 The block SHALL expose parameter JUMP_V, 8: magnitude of the upward velocity set by a jump.
REQ-008 The block SHALL expose parameter VMAX, 12: maximum downward velocity.
REQ-009 The block SHALL expose parameter COLOR, 12'h0F0: normal bird colour.
REQ-010 The block SHALL expose parameter FLAP_COLOR, 12'hFF0: bird colour after a jump.
REQ-011 The block SHALL expose parameter FLAP_FRAMES, 4: number of frames the flap colour is shown.

Ports (name, direction, width, meaning):
REQ-012 The block SHALL provide port clk, input, 1: the single clock.
REQ-013 The block SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-014 The block SHALL provide port game_rst, input, 1: synchronous new-game restart.
REQ-015 The block SHALL provide port mouse_left, input, 1: jump button, level.
REQ-016 The block SHALL provide port vin, vga_if.in: the hcount and vcount timing source.
REQ-017 The block SHALL provide port rgb, output, 12: pixel colour.
REQ-018 The block SHALL provide port valid, output, 1: pixel belongs to the bird.
REQ-019 The block SHALL provide port collision, output, 1: bird has hit the floor.

Function
REQ-020 Frame tick SHALL be a one-cycle pulse when vin.hcount == 0 and vin.vcount == SCREEN_H; all physics updates SHALL occur only on the tick.
REQ-021 A rising edge of mouse_left SHALL be detected against a registered copy and latched as jump_pend; jump_pend SHALL be cleared on the next tick, and multiple edges within one frame SHALL count as one jump.
REQ-022 The FSM SHALL have states IDLE, FLY and DEAD; reset and game_rst SHALL enter IDLE.
REQ-023 In IDLE: y SHALL hold at Y_START and vel SHALL be 0; a tick with jump_pend set SHALL move to FLY and apply the jump update on that same tick.
REQ-024 In FLY, on each tick: vel_next SHALL be -JUMP_V if jump_pend is set, else min(vel + GRAVITY, VMAX).
REQ-025 In FLY, on each tick: y_next SHALL be y + vel_next, computed as a signed value with at least 12 bits.
REQ-026 Ceiling rule: if y_next < 0, then y SHALL be 0 and vel SHALL be 0.
REQ-027 Floor rule: if y_next >= SCREEN_H - BIRD_H, then y SHALL be SCREEN_H - BIRD_H, vel SHALL be 0, state SHALL go to DEAD, and collision SHALL be 1 from the following cycle.
REQ-028 In DEAD: y, vel and collision SHALL be frozen, mouse_left SHALL be ignored, and only game_rst SHALL exit the state.
REQ-029 game_rst SHALL take priority over the tick in the same cycle: y = Y_START, vel = 0, jump_pend = 0, flap counter = 0, collision = 0.
REQ-030 Each applied jump SHALL load the flap counter with FLAP_FRAMES; the counter SHALL decrement once per tick and saturate at 0.
REQ-031 Draw: rgb and valid SHALL be registered with 1-cycle latency after vin.
REQ-032 Hit condition: BIRD_X <= hcount < BIRD_X + BIRD_W and y <= vcount < y + BIRD_H.
REQ-033 On a hit, valid SHALL be 1 and rgb SHALL be FLAP_COLOR if the flap counter is nonzero, else COLOR; on a miss, rgb SHALL be 12'h000 and valid SHALL be 0.
REQ-034 Because y changes only at vcount == SCREEN_H, a visible frame SHALL never be drawn with two different y values.

Reset
REQ-035 When rst_n is low, the block SHALL asynchronously set: state IDLE, y = Y_START, vel = 0, jump_pend = 0, the mouse_left edge register = 0, flap counter = 0, rgb = 12'h000, valid = 0, collision = 0.
REQ-036 rst_n asserted mid-frame or in DEAD SHALL give the same result as REQ-035; after release, operation SHALL resume at the next tick.

Verification
REQ-037 Post-reset pixel check: vin at (400,300) -> next cycle rgb = 0F0 and valid = 1; at (440,300) -> rgb = 000, valid = 0; at (400,350) -> valid = 0.
REQ-038 Single click in IDLE, then ticks -> tick 1: y = 292, vel = -8; tick 2: y = 285, vel = -7; rgb = FF0 for 4 frames, then 0F0.
REQ-039 Three mouse_left pulses within one frame -> exactly one jump is applied (y decreases by 8 on that tick only).
REQ-040 One click, then no input -> y rises to 264, then falls with vel capped at 12 -> y = 550, collision = 1, state DEAD; further clicks leave y = 550.
REQ-041 Repeated clicks near the top with y_next < 0 -> y = 0 and vel = 0 on that tick, with no wrap to a large value.
REQ-042 game_rst asserted on the same cycle as a tick while in DEAD -> y = 300, collision = 0, state IDLE; rst_n pulsed low mid-line -> outputs are 0 immediately, without waiting for a clock edge.
